// File: rtl/ili9341_spi_stream.sv
// ili9341_spi_stream
//   SPI write engine for ILI9341-class panels. After reset it drives the panel
//   hardware-reset pulse and power-up wait, then serialises a valid/ready stream
//   of command/data words (8 or DATA_W bits, MSB first, SPI mode 0). Words
//   accepted in the last cycle of a transfer follow with no gap and CS held low.
//
//   Optional feature: define ILI9341_DELAY_CMD_EN to turn words with in_delay=1
//   into inline waits of in_data*DELAY_UNIT cycles (CS high). Without the macro
//   in_delay is ignored and no delay hardware exists.
//
// Ports
//   sysclk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready    word handshake (transfer when both high)
//   in_data, in_dc       word (MSB first; narrow words use [7:0]) and its D/C level
//   in_wide, in_delay    1: send DATA_W bits / 1: word is a delay request
//   tft_rst, tft_cs      panel reset and chip select, both active low
//   tft_dc, tft_clk      panel D/C, SPI clock (idle low)
//   tft_din              SPI MOSI
//   init_done            sticky high once the reset sequence has finished
//   busy                 high whenever the engine is not idle
//
// state      | meaning
// RST_LOW    | tft_rst held low for RST_LOW_CYCLES
// RST_WAIT   | tft_rst high, waiting RST_WAIT_CYCLES before the first word
// IDLE       | CS high, ready for a word
// SHIFT      | clocking a word out; ready again in its last cycle
// DELAY      | inline delay request in progress (ILI9341_DELAY_CMD_EN only)
module ili9341_spi_stream #(
  parameter int CLK_DIV         = 1,
  parameter int DATA_W          = 16,
  parameter int RST_LOW_CYCLES  = 60,
  parameter int RST_WAIT_CYCLES = 720000,
  parameter int DELAY_UNIT      = 6000
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dc,
  input  logic              in_wide,
  input  logic              in_delay,
  output logic              tft_rst,
  output logic              tft_cs,
  output logic              tft_dc,
  output logic              tft_clk,
  output logic              tft_din,
  output logic              init_done,
  output logic              busy
);

  localparam int RST_MAX = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
  localparam int RST_W   = $clog2(RST_MAX + 1);
  localparam int DIV_W   = $clog2(CLK_DIV + 1);
  localparam int BIT_W   = $clog2(DATA_W + 1);
`ifdef ILI9341_DELAY_CMD_EN
  localparam int DLY_W   = DATA_W + $clog2(DELAY_UNIT + 1);
`endif

  typedef enum logic [2:0] {
    S_RST_LOW  = 3'd0,
    S_RST_WAIT = 3'd1,
    S_IDLE     = 3'd2,
    S_SHIFT    = 3'd3
`ifdef ILI9341_DELAY_CMD_EN
    , S_DELAY  = 3'd4
`endif
  } state_t;

  state_t            state, state_nx;
  logic [RST_W-1:0]  cnt, cnt_nx;
  logic [DIV_W-1:0]  div_cnt, div_nx;
  logic [BIT_W-1:0]  bit_cnt, bit_nx;
  logic [DATA_W-1:0] shreg, shreg_nx, ld_word;
  logic              rst_nx, cs_nx, dc_nx, clk_nx, din_nx, done_nx, ready_nx, busy_nx;
  logic              take, load;
`ifdef ILI9341_DELAY_CMD_EN
  logic [DLY_W-1:0]  dly, dly_nx;
`else
  logic              unused_delay;
  assign unused_delay = in_delay & (DELAY_UNIT >= 0);
`endif

  // Narrow words are left-aligned so the shifter always emits from its MSB.
  assign ld_word = in_wide ? in_data : (in_data << (DATA_W - 8));

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state     <= S_RST_LOW;
      cnt       <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tft_rst   <= 1'b0;
      tft_cs    <= 1'b1;
      tft_dc    <= 1'b0;
      tft_clk   <= 1'b0;
      tft_din   <= 1'b0;
      init_done <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b1;
`ifdef ILI9341_DELAY_CMD_EN
      dly       <= '0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      div_cnt   <= div_nx;
      bit_cnt   <= bit_nx;
      shreg     <= shreg_nx;
      tft_rst   <= rst_nx;
      tft_cs    <= cs_nx;
      tft_dc    <= dc_nx;
      tft_clk   <= clk_nx;
      tft_din   <= din_nx;
      init_done <= done_nx;
      in_ready  <= ready_nx;
      busy      <= busy_nx;
`ifdef ILI9341_DELAY_CMD_EN
      dly       <= dly_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    div_nx   = div_cnt;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    rst_nx   = tft_rst;
    cs_nx    = tft_cs;
    dc_nx    = tft_dc;
    clk_nx   = tft_clk;
    din_nx   = tft_din;
    done_nx  = init_done;
`ifdef ILI9341_DELAY_CMD_EN
    dly_nx   = dly;
`endif
    take     = in_valid & in_ready;
    load     = 1'b0;

    case (state)
      S_RST_LOW: begin
        if (cnt == RST_W'(RST_LOW_CYCLES - 1)) begin
          cnt_nx   = '0;
          rst_nx   = 1'b1;
          state_nx = S_RST_WAIT;
        end else begin
          cnt_nx = cnt + RST_W'(1);
        end
      end
      S_RST_WAIT: begin
        if (cnt == RST_W'(RST_WAIT_CYCLES - 1)) begin
          cnt_nx   = '0;
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt + RST_W'(1);
        end
      end
      S_IDLE: begin
        cs_nx  = 1'b1;
        clk_nx = 1'b0;
        load   = take;
      end
      S_SHIFT: begin
        if (div_cnt != '0) begin
          div_nx = div_cnt - DIV_W'(1);
        end else begin
          div_nx = DIV_W'(CLK_DIV - 1);
          if (!tft_clk) begin
            clk_nx = 1'b1;
          end else if (bit_cnt == BIT_W'(1)) begin
            // Falling edge after the last bit: chain the next word or release CS.
            if (take) begin
              load = 1'b1;
            end else begin
              cs_nx    = 1'b1;
              clk_nx   = 1'b0;
              state_nx = S_IDLE;
            end
          end else begin
            clk_nx   = 1'b0;
            shreg_nx = shreg << 1;
            din_nx   = shreg[DATA_W-2];
            bit_nx   = bit_cnt - BIT_W'(1);
          end
        end
      end
`ifdef ILI9341_DELAY_CMD_EN
      S_DELAY: begin
        if (dly <= DLY_W'(1)) state_nx = S_IDLE;
        else                  dly_nx   = dly - DLY_W'(1);
      end
`endif
      default: state_nx = S_RST_LOW;
    endcase

    if (load) begin
`ifdef ILI9341_DELAY_CMD_EN
      if (in_delay) begin
        state_nx = S_DELAY;
        cs_nx    = 1'b1;
        clk_nx   = 1'b0;
        dly_nx   = DLY_W'(in_data) * DLY_W'(DELAY_UNIT);
      end else
`endif
      begin
        state_nx = S_SHIFT;
        shreg_nx = ld_word;
        din_nx   = ld_word[DATA_W-1];
        dc_nx    = in_dc;
        cs_nx    = 1'b0;
        clk_nx   = 1'b0;
        div_nx   = DIV_W'(CLK_DIV - 1);
        bit_nx   = in_wide ? BIT_W'(DATA_W) : BIT_W'(8);
      end
    end

    // Ready is registered, so it is raised one cycle ahead of the cycle that accepts.
    ready_nx = (state_nx == S_IDLE) ||
               ((state_nx == S_SHIFT) && clk_nx && (bit_nx == BIT_W'(1)) && (div_nx == '0));
    busy_nx  = (state_nx != S_IDLE);
  end

endmodule
